decode_queue: RTL and testbench

Parametrised, registered successor to the single-cycle instruction decoder. Accepts fetched instructions over a valid/ready handshake, decodes each into a one-hot `choose` vector with an explicit illegal flag, and buffers decoded entries in a DEPTH-entry FIFO. The FIFO decouples the fetch stage from the execute stage of the MIPS CPU. An optional extension mode adds the HI/LO, multiply/divide and `jalr` instructions.

---
 rtl/decode_queue_pkg.sv | 111 +++++++++++
 rtl/decode_queue_if.sv | 31 +++
 rtl/decode_queue_core.sv | 96 +++++++++
 rtl/decode_queue.sv | 116 +++++++++++
 tb/tb_decode_queue.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_queue_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared constants for the decode queue: MIPS opcode/funct encodings, the bit
// position of every instruction inside the one-hot `choose` vector, and small
// field-extraction helpers.
// -----------------------------------------------------------------------------
package decode_pkg;

  typedef logic [5:0] field_t;   // opcode or funct field
  typedef logic [5:0] idx_t;     // bit position inside choose

  localparam int NUM_BASE_OPS = 31;
  localparam int NUM_EXT_OPS  = 9;

  // Primary opcodes
  localparam field_t OPC_RTYPE = 6'h00;
  localparam field_t OPC_J     = 6'h02;
  localparam field_t OPC_JAL   = 6'h03;
  localparam field_t OPC_BEQ   = 6'h04;
  localparam field_t OPC_BNE   = 6'h05;
  localparam field_t OPC_ADDI  = 6'h08;
  localparam field_t OPC_ADDIU = 6'h09;
  localparam field_t OPC_SLTI  = 6'h0A;
  localparam field_t OPC_SLTIU = 6'h0B;
  localparam field_t OPC_ANDI  = 6'h0C;
  localparam field_t OPC_ORI   = 6'h0D;
  localparam field_t OPC_XORI  = 6'h0E;
  localparam field_t OPC_LUI   = 6'h0F;
  localparam field_t OPC_LW    = 6'h23;
  localparam field_t OPC_SW    = 6'h2B;

  // R-type funct codes
  localparam field_t FN_SLL   = 6'h00;
  localparam field_t FN_SRL   = 6'h02;
  localparam field_t FN_SRA   = 6'h03;
  localparam field_t FN_SLLV  = 6'h04;
  localparam field_t FN_SRLV  = 6'h06;
  localparam field_t FN_SRAV  = 6'h07;
  localparam field_t FN_JR    = 6'h08;
  localparam field_t FN_JALR  = 6'h09;
  localparam field_t FN_MFHI  = 6'h10;
  localparam field_t FN_MTHI  = 6'h11;
  localparam field_t FN_MFLO  = 6'h12;
  localparam field_t FN_MTLO  = 6'h13;
  localparam field_t FN_MULT  = 6'h18;
  localparam field_t FN_MULTU = 6'h19;
  localparam field_t FN_DIV   = 6'h1A;
  localparam field_t FN_DIVU  = 6'h1B;
  localparam field_t FN_ADD   = 6'h20;
  localparam field_t FN_ADDU  = 6'h21;
  localparam field_t FN_SUB   = 6'h22;
  localparam field_t FN_SUBU  = 6'h23;
  localparam field_t FN_AND   = 6'h24;
  localparam field_t FN_OR    = 6'h25;
  localparam field_t FN_XOR   = 6'h26;
  localparam field_t FN_NOR   = 6'h27;
  localparam field_t FN_SLT   = 6'h2A;
  localparam field_t FN_SLTU  = 6'h2B;

  // Bit positions in choose: base set
  localparam idx_t IDX_ADD   = 6'd0;
  localparam idx_t IDX_ADDU  = 6'd1;
  localparam idx_t IDX_SUB   = 6'd2;
  localparam idx_t IDX_SUBU  = 6'd3;
  localparam idx_t IDX_AND   = 6'd4;
  localparam idx_t IDX_OR    = 6'd5;
  localparam idx_t IDX_XOR   = 6'd6;
  localparam idx_t IDX_NOR   = 6'd7;
  localparam idx_t IDX_SLT   = 6'd8;
  localparam idx_t IDX_SLTU  = 6'd9;
  localparam idx_t IDX_SLL   = 6'd10;
  localparam idx_t IDX_SRL   = 6'd11;
  localparam idx_t IDX_SRA   = 6'd12;
  localparam idx_t IDX_SLLV  = 6'd13;
  localparam idx_t IDX_SRLV  = 6'd14;
  localparam idx_t IDX_SRAV  = 6'd15;
  localparam idx_t IDX_JR    = 6'd16;
  localparam idx_t IDX_ADDI  = 6'd17;
  localparam idx_t IDX_ADDIU = 6'd18;
  localparam idx_t IDX_ANDI  = 6'd19;
  localparam idx_t IDX_ORI   = 6'd20;
  localparam idx_t IDX_XORI  = 6'd21;
  localparam idx_t IDX_LW    = 6'd22;
  localparam idx_t IDX_SW    = 6'd23;
  localparam idx_t IDX_BEQ   = 6'd24;
  localparam idx_t IDX_BNE   = 6'd25;
  localparam idx_t IDX_SLTI  = 6'd26;
  localparam idx_t IDX_SLTIU = 6'd27;
  localparam idx_t IDX_LUI   = 6'd28;
  localparam idx_t IDX_J     = 6'd29;
  localparam idx_t IDX_JAL   = 6'd30;
  // Bit positions in choose: extension set
  localparam idx_t IDX_MFHI  = 6'd31;
  localparam idx_t IDX_MFLO  = 6'd32;
  localparam idx_t IDX_MTHI  = 6'd33;
  localparam idx_t IDX_MTLO  = 6'd34;
  localparam idx_t IDX_MULT  = 6'd35;
  localparam idx_t IDX_MULTU = 6'd36;
  localparam idx_t IDX_DIV   = 6'd37;
  localparam idx_t IDX_DIVU  = 6'd38;
  localparam idx_t IDX_JALR  = 6'd39;

  function automatic field_t opcode_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic field_t funct_of(input logic [31:0] inst);
    return inst[5:0];
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// decode_queue_if
// Handshake bundle of the decode queue.
//   in_*  : fetch side (valid/ready, instruction word and PC)
//   out_* : execute side (valid/ready, decoded head entry)
// Modports: slave = the queue itself, master = the environment driving it.
// -----------------------------------------------------------------------------
interface decode_queue_if #(
  parameter int OP_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_choose;
  logic            out_illegal;
  logic [31:0]     out_inst;
  logic [31:0]     out_pc;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_choose, out_illegal, out_inst, out_pc
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_choose, out_illegal, out_inst, out_pc
  );
endinterface

// File: rtl/decode_queue_core.sv
// -----------------------------------------------------------------------------
// inst_decode_core
// Purely combinational MIPS decoder: instruction word -> one-hot choose vector
// plus an illegal flag. Extension instructions decode only when EXT_EN=1.
//   i_inst    in  32    instruction word
//   o_choose  out OP_W  one-hot decode, all-zero when illegal
//   o_illegal out 1     instruction not recognised
// -----------------------------------------------------------------------------
module inst_decode_core
  import decode_pkg::*;
#(
  parameter int OP_W   = 32,
  parameter bit EXT_EN = 1'b0
) (
  input  logic [31:0]     i_inst,
  output logic [OP_W-1:0] o_choose,
  output logic            o_illegal
);

  field_t w_opcode;
  field_t w_funct;
  idx_t   w_idx;
  logic   w_hit;
  logic   w_unused_fields;

  assign w_opcode        = opcode_of(i_inst);
  assign w_funct         = funct_of(i_inst);
  // Register/immediate fields play no part in classifying the instruction.
  assign w_unused_fields = ^i_inst[25:6];

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_hit = 1'b1;
    w_idx = '0;
    case (w_opcode)
      OPC_RTYPE: begin
        case (w_funct)
          FN_ADD:   w_idx = IDX_ADD;
          FN_ADDU:  w_idx = IDX_ADDU;
          FN_SUB:   w_idx = IDX_SUB;
          FN_SUBU:  w_idx = IDX_SUBU;
          FN_AND:   w_idx = IDX_AND;
          FN_OR:    w_idx = IDX_OR;
          FN_XOR:   w_idx = IDX_XOR;
          FN_NOR:   w_idx = IDX_NOR;
          FN_SLT:   w_idx = IDX_SLT;
          FN_SLTU:  w_idx = IDX_SLTU;
          FN_SLL:   w_idx = IDX_SLL;
          FN_SRL:   w_idx = IDX_SRL;
          FN_SRA:   w_idx = IDX_SRA;
          FN_SLLV:  w_idx = IDX_SLLV;
          FN_SRLV:  w_idx = IDX_SRLV;
          FN_SRAV:  w_idx = IDX_SRAV;
          FN_JR:    w_idx = IDX_JR;
          // Extension functs are only legal when the extension is built in.
          FN_MFHI:  begin w_idx = IDX_MFHI;  w_hit = EXT_EN; end
          FN_MFLO:  begin w_idx = IDX_MFLO;  w_hit = EXT_EN; end
          FN_MTHI:  begin w_idx = IDX_MTHI;  w_hit = EXT_EN; end
          FN_MTLO:  begin w_idx = IDX_MTLO;  w_hit = EXT_EN; end
          FN_MULT:  begin w_idx = IDX_MULT;  w_hit = EXT_EN; end
          FN_MULTU: begin w_idx = IDX_MULTU; w_hit = EXT_EN; end
          FN_DIV:   begin w_idx = IDX_DIV;   w_hit = EXT_EN; end
          FN_DIVU:  begin w_idx = IDX_DIVU;  w_hit = EXT_EN; end
          FN_JALR:  begin w_idx = IDX_JALR;  w_hit = EXT_EN; end
          default:  w_hit = 1'b0;
        endcase
      end
      OPC_ADDI:  w_idx = IDX_ADDI;
      OPC_ADDIU: w_idx = IDX_ADDIU;
      OPC_ANDI:  w_idx = IDX_ANDI;
      OPC_ORI:   w_idx = IDX_ORI;
      OPC_XORI:  w_idx = IDX_XORI;
      OPC_LW:    w_idx = IDX_LW;
      OPC_SW:    w_idx = IDX_SW;
      OPC_BEQ:   w_idx = IDX_BEQ;
      OPC_BNE:   w_idx = IDX_BNE;
      OPC_SLTI:  w_idx = IDX_SLTI;
      OPC_SLTIU: w_idx = IDX_SLTIU;
      OPC_LUI:   w_idx = IDX_LUI;
      OPC_J:     w_idx = IDX_J;
      OPC_JAL:   w_idx = IDX_JAL;
      default:   w_hit = 1'b0;
    endcase
  end

  // One-hot expansion; indices beyond OP_W simply never light a bit.
  always_comb begin
    o_choose = '0;
    for (int b = 0; b < OP_W; b++) begin
      o_choose[b] = w_hit && (int'(w_idx) == b);
    end
    o_illegal = !w_hit;
  end

endmodule

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
// Decodes fetched instructions on entry and buffers {choose, illegal, inst, pc}
// in a DEPTH-entry FIFO between fetch and execute.
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   flush        in  1      synchronous discard of all buffered entries
//   bus          slave      in_* fetch handshake, out_* execute handshake
//   illegal_cnt  out CNT_W  saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module decode_queue
  import decode_pkg::*;
#(
  parameter int OP_W   = 32,
  parameter int DEPTH  = 2,
  parameter bit EXT_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_queue_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [OP_W-1:0]  w_choose;
  logic             w_illegal;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  logic [OP_W-1:0]  r_choose  [DEPTH];
  logic             r_illegal [DEPTH];
  logic [31:0]      r_inst    [DEPTH];
  logic [31:0]      r_pc      [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [CNT_W-1:0] r_ill_cnt;

  inst_decode_core #(
    .OP_W   (OP_W),
    .EXT_EN (EXT_EN)
  ) u_decode (
    .i_inst    (bus.in_inst),
    .o_choose  (w_choose),
    .o_illegal (w_illegal)
  );

  assign w_full  = (r_count == OCC_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // Full blocks a push even when a pop happens in the same cycle, which keeps
  // in_ready free of any combinational path from out_ready.
  assign w_push  = bus.in_valid && !w_full && !flush;
  assign w_pop   = !w_empty && bus.out_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks evaluate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + OCC_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - OCC_W'(1);
    end
  end

  // NOTE: the storage array is reset deliberately: the head fields drive the
  // outputs directly and must read as zero out of reset. A large FIFO would
  // normally leave the payload unreset and rely on out_valid instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_choose[i]  <= '0;
        r_illegal[i] <= 1'b0;
        r_inst[i]    <= '0;
        r_pc[i]      <= '0;
      end
    end else if (w_push) begin
      r_choose[r_wr_ptr]  <= w_choose;
      r_illegal[r_wr_ptr] <= w_illegal;
      r_inst[r_wr_ptr]    <= bus.in_inst;
      r_pc[r_wr_ptr]      <= bus.in_pc;
    end
  end

  // Only reset clears the counter; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_push && w_illegal && !(&r_ill_cnt)) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready    = !w_full;
  assign bus.out_valid   = !w_empty;
  assign bus.out_choose  = r_choose[r_rd_ptr];
  assign bus.out_illegal = r_illegal[r_rd_ptr];
  assign bus.out_inst    = r_inst[r_rd_ptr];
  assign bus.out_pc      = r_pc[r_rd_ptr];
  assign illegal_cnt     = r_ill_cnt;

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
// Two queues share one stimulus stream: a base build (OP_W=32, EXT_EN=0,
// CNT_W=16) and an extended build (OP_W=40, EXT_EN=1, CNT_W=3 so saturation is
// reachable). Both have DEPTH=2, so one occupancy model serves both; decode is
// predicted from lookup tables of the instruction set.
// -----------------------------------------------------------------------------
module tb_decode_queue;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Instruction set tables, listed in choose-bit order.
  localparam logic [5:0] R_FN [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02,
                                       6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] I_OP [14] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23,
                                       6'h2B, 6'h04, 6'h05, 6'h0A, 6'h0B, 6'h0F,
                                       6'h02, 6'h03};
  localparam logic [5:0] X_FN [9]  = '{6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19,
                                       6'h1A, 6'h1B, 6'h09};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ordy, s_flush;
  logic [31:0] s_inst, s_pc;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int   n_vec  = 0;
  int   n_miss = 0;
  bit   cmp_en = 1'b0;
  ent_t m_q[$];
  int   m_ill0, m_ill1;

  always #5 clk = ~clk;

  decode_queue_if #(.OP_W(32)) bus0 ();
  decode_queue_if #(.OP_W(40)) bus1 ();

  assign bus0.in_valid  = s_valid;
  assign bus0.in_inst   = s_inst;
  assign bus0.in_pc     = s_pc;
  assign bus0.out_ready = s_ordy;
  assign bus1.in_valid  = s_valid;
  assign bus1.in_inst   = s_inst;
  assign bus1.in_pc     = s_pc;
  assign bus1.out_ready = s_ordy;

  decode_queue #(.OP_W(32), .DEPTH(DEPTH), .EXT_EN(1'b0), .CNT_W(16)) u_dq0 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .bus(bus0), .illegal_cnt(cnt0)
  );

  decode_queue #(.OP_W(40), .DEPTH(DEPTH), .EXT_EN(1'b1), .CNT_W(3)) u_dq1 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .bus(bus1), .illegal_cnt(cnt1)
  );

  // ---------------------------------------------------------------- model ----
  function automatic int ref_idx(input logic [31:0] inst, input bit ext);
    logic [5:0] op = inst[31:26];
    logic [5:0] fn = inst[5:0];
    if (op == 6'h00) begin
      for (int i = 0; i < 17; i++) if (fn == R_FN[i]) return i;
      if (ext) for (int i = 0; i < 9; i++) if (fn == X_FN[i]) return 31 + i;
      return -1;
    end
    for (int i = 0; i < 14; i++) if (op == I_OP[i]) return 17 + i;
    return -1;
  endfunction

  function automatic logic [63:0] ref_choose(input logic [31:0] inst, input bit ext);
    int k = ref_idx(inst, ext);
    return (k < 0) ? 64'd0 : (64'd1 << k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_update();
    bit push, pop;
    push = s_valid && (m_q.size() < DEPTH) && !s_flush;
    pop  = (m_q.size() > 0) && s_ordy && !s_flush;
    if (s_flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{inst: s_inst, pc: s_pc});
        if (ref_idx(s_inst, 1'b0) < 0 && m_ill0 < 65535) m_ill0++;
        if (ref_idx(s_inst, 1'b1) < 0 && m_ill1 < 7)     m_ill1++;
      end
    end
  endtask

  task automatic compare_all();
    bit   exp_valid;
    ent_t h;
    exp_valid = (m_q.size() != 0);
    check("q0.out_valid",   bus0.out_valid, exp_valid);
    check("q1.out_valid",   bus1.out_valid, exp_valid);
    check("q0.in_ready",    bus0.in_ready,  m_q.size() < DEPTH);
    check("q1.in_ready",    bus1.in_ready,  m_q.size() < DEPTH);
    check("q0.illegal_cnt", cnt0, m_ill0);
    check("q1.illegal_cnt", cnt1, m_ill1);
    if (exp_valid) begin
      h = m_q[0];
      check("q0.out_choose",  bus0.out_choose,  ref_choose(h.inst, 1'b0));
      check("q1.out_choose",  bus1.out_choose,  ref_choose(h.inst, 1'b1));
      check("q0.out_illegal", bus0.out_illegal, ref_idx(h.inst, 1'b0) < 0);
      check("q1.out_illegal", bus1.out_illegal, ref_idx(h.inst, 1'b1) < 0);
      check("q0.out_inst",    bus0.out_inst,    h.inst);
      check("q1.out_inst",    bus1.out_inst,    h.inst);
      check("q0.out_pc",      bus0.out_pc,      h.pc);
      check("q1.out_pc",      bus1.out_pc,      h.pc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) compare_all();
  end

  // ------------------------------------------------------------- stimulus ----
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    s_valid = v; s_inst = inst; s_pc = pc; s_ordy = ordy; s_flush = fl;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0:       w[31:26] = 6'h00;                               // R-type, any funct
      1:       w[31:26] = I_OP[$urandom_range(0, 13)];         // legal I/J-type
      default: ;                                               // anything at all
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    m_ill0 = 0; m_ill1 = 0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    check("rst.out_valid",   bus0.out_valid,   1'b0);
    check("rst.in_ready",    bus0.in_ready,    1'b1);
    check("rst.out_choose",  bus0.out_choose,  32'd0);
    check("rst.out_illegal", bus0.out_illegal, 1'b0);
    check("rst.out_inst",    bus0.out_inst,    32'd0);
    check("rst.out_pc",      bus0.out_pc,      32'd0);
    check("rst.illegal_cnt", cnt0,             16'd0);
    check("rst.q1_choose",   bus1.out_choose,  40'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // add, one-cycle latency into an empty queue
    drive(1'b1, 32'h01095020, 32'h00400000, 1'b1, 1'b0);
    cyc();
    check("add.out_valid",   bus0.out_valid,   1'b1);
    check("add.out_choose",  bus0.out_choose,  32'h1);
    check("add.out_illegal", bus0.out_illegal, 1'b0);
    check("add.out_pc",      bus0.out_pc,      32'h00400000);

    // lui then j, back-to-back, one head per cycle
    drive(1'b1, 32'h3C011001, 32'h00400004, 1'b1, 1'b0);
    cyc();
    check("lui.out_choose", bus0.out_choose, 32'h1000_0000);
    drive(1'b1, 32'h08100000, 32'h00400008, 1'b1, 1'b0);
    cyc();
    check("j.out_choose",   bus0.out_choose, 32'h2000_0000);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();

    // two illegal words
    drive(1'b1, 32'hFC000000, 32'h10, 1'b1, 1'b0);
    cyc();
    check("ill1.out_illegal", bus0.out_illegal, 1'b1);
    check("ill1.out_choose",  bus0.out_choose,  32'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h00000001, 32'h14, 1'b1, 1'b0);
    cyc();
    check("ill2.out_illegal", bus0.out_illegal, 1'b1);
    check("ill2.out_choose",  bus0.out_choose,  32'd0);
    check("ill2.illegal_cnt", cnt0, 16'd2);

    // mfhi: illegal in the base build, bit 31 in the extended build
    drive(1'b1, 32'h00005010, 32'h18, 1'b1, 1'b0);
    cyc();
    check("mfhi.q0_illegal", bus0.out_illegal, 1'b1);
    check("mfhi.q1_choose",  bus1.out_choose,  40'h00_8000_0000);
    check("mfhi.q1_illegal", bus1.out_illegal, 1'b0);
    check("mfhi.q1_cnt",     cnt1, 3'd2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();

    // back-pressure: third push held until a slot frees
    drive(1'b1, 32'h00000021, 32'h100, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h34000000, 32'h104, 1'b0, 1'b0);
    cyc();
    check("bp.in_ready_full", bus0.in_ready, 1'b0);
    drive(1'b1, 32'hAC000000, 32'h108, 1'b0, 1'b0);
    cyc();
    check("bp.held_in_ready", bus0.in_ready, 1'b0);
    check("bp.head_stable",   bus0.out_pc,   32'h100);
    drive(1'b1, 32'hAC000000, 32'h108, 1'b1, 1'b0);
    cyc();
    check("bp.second_head", bus0.out_pc,   32'h104);
    check("bp.ready_again", bus0.in_ready, 1'b1);
    cyc();
    check("bp.third_head",  bus0.out_pc,   32'h108);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    check("bp.drained",     bus0.out_valid, 1'b0);

    // flush with a full queue and with a push that would otherwise land
    drive(1'b1, 32'h01095020, 32'h200, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h01095020, 32'h204, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'hFC000000, 32'h208, 1'b0, 1'b1);
    cyc();
    check("flush.out_valid", bus0.out_valid, 1'b0);
    check("flush.in_ready",  bus0.in_ready,  1'b1);
    check("flush.cnt",       cnt0, 16'd3);
    drive(1'b1, 32'h3C011001, 32'h20C, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h00000001, 32'h210, 1'b0, 1'b1);
    cyc();
    check("flush2.out_valid", bus0.out_valid, 1'b0);
    check("flush2.cnt0",      cnt0, 16'd3);
    check("flush2.cnt1",      cnt1, 3'd2);

    // randomized traffic: a free-flowing phase, then a congested one
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom,
            (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            $urandom_range(0, 31) == 0);
      cyc();
    end
    check("sat.q1_cnt", cnt1, 3'd7);

    // asynchronous reset in the middle of a transfer
    drive(1'b1, 32'h01095020, 32'h300, 1'b0, 1'b0);
    cyc();
    cyc();
    check("arst.pre_valid", bus0.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_ill0 = 0;
    m_ill1 = 0;
    check("arst.out_valid",   bus0.out_valid,   1'b0);
    check("arst.in_ready",    bus0.in_ready,    1'b1);
    check("arst.out_choose",  bus0.out_choose,  32'd0);
    check("arst.out_illegal", bus0.out_illegal, 1'b0);
    check("arst.out_inst",    bus0.out_inst,    32'd0);
    check("arst.out_pc",      bus0.out_pc,      32'd0);
    check("arst.cnt0",        cnt0,             16'd0);
    check("arst.cnt1",        cnt1,             3'd0);
    check("arst.q1_valid",    bus1.out_valid,   1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h400, 1'b1, 1'b0);
    cyc();
    check("post.out_pc", bus0.out_pc, 32'h400);
    check("post.cnt0",   cnt0, 16'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
